// File: rtl/bus_cycle_master_8088.sv
// -----------------------------------------------------------------------------
// bus_cycle_master_8088
//
// Minimum-mode 8088 bus-cycle initiator. A single-request command port
// (req/we/io/addr/wdata) is turned into T1-T2-T3-(Tw)-T4 cycles on the
// multiplexed 8088 bus, so the address latch, 8286 transceiver, chip-select
// decode and memory/IO responders can be driven by a synthesizable master.
//
// Parameters
//   WAIT_MAX  maximum consecutive Tw states before the cycle is aborted (1..255)
//   AW        memory address width; IO cycles use only the low 16 bits
//
// Ports
//   CLK     in     bus clock, all state changes on the rising edge
//   RESET   in     asynchronous active-high reset
//   req     in     command request, held stable until ack or err
//   we      in     1 = write, 0 = read
//   io      in     1 = IO cycle, 0 = memory cycle
//   addr    in     cycle address [AW-1:0]
//   wdata   in     write data
//   rdata   out    read data, valid while ack=1 on a read
//   ack     out    one-cycle pulse in T4 on successful completion
//   err     out    one-cycle pulse after a wait-state timeout
//   busy    out    high from T1 through T4
//   READY   in     responder ready, sampled at the end of T3/Tw
//   ALE     out    address latch enable, high during T1 only
//   RD      out    read strobe, active low
//   WR      out    write strobe, active low
//   IOM     out    1 = IO, 0 = memory
//   DTR     out    transceiver direction, 1 = transmit (write)
//   DEN     out    transceiver enable, active low
//   A       out    upper address bits [AW-1:8]
//   AD      inout  multiplexed address/data
// -----------------------------------------------------------------------------
module bus_cycle_master_8088 #(
  parameter int WAIT_MAX = 15,
  parameter int AW       = 20
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req,
  input  logic          we,
  input  logic          io,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          ack,
  output logic          err,
  output logic          busy,
  input  logic          READY,
  output logic          ALE,
  output logic          RD,
  output logic          WR,
  output logic          IOM,
  output logic          DTR,
  output logic          DEN,
  output logic [AW-9:0] A,
  inout  wire  [7:0]    AD
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  // IO cycles only carry a 16-bit port address; everything above bit 15 is
  // forced low on the bus.
  logic [AW-1:0] io_mask;
  for (genvar gi = 0; gi < AW; gi++) begin : g_io_mask
    assign io_mask[gi] = (gi < 16) ? 1'b1 : 1'b0;
  end

  // Command fields captured at the start of each cycle.
  state_t        state_q,    state_d;
  logic          we_q,       we_d;
  logic          io_q,       io_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [7:0]    wdata_q,    wdata_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;

  // Registered outputs.
  logic [7:0]    rdata_q,    rdata_d;
  logic          ack_q,      ack_d;
  logic          err_q,      err_d;
  logic          busy_q,     busy_d;
  logic          ale_q,      ale_d;
  logic          rd_q,       rd_d;
  logic          wr_q,       wr_d;
  logic          iom_q,      iom_d;
  logic          dtr_q,      dtr_d;
  logic          den_q,      den_d;
  logic [AW-9:0] a_q,        a_d;
  logic [7:0]    ad_out_q,   ad_out_d;
  logic          ad_oe_q,    ad_oe_d;

  logic [AW-1:0] bus_addr_d;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    io_d       = io_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    // ---------------- next-state / command latch ----------------
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          io_d    = io;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = S_T1;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        if (READY) begin
          state_d    = S_T4;
          ack_d      = 1'b1;
          wait_cnt_d = 8'd0;
          // The responder is driving AD at this edge on a read.
          if (!we_q) begin
            rdata_d = AD;
          end
        end else if ((state_q == S_TW) && (wait_cnt_q == WAIT_LIMIT)) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          wait_cnt_d = 8'd0;
        end else begin
          state_d    = S_TW;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_T4: begin
        wait_cnt_d = 8'd0;
        // Back-to-back: a held req starts the next T1 with fresh fields.
        if (req) begin
          we_d    = we;
          io_d    = io;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = S_T1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    bus_addr_d = io_d ? (addr_d & io_mask) : addr_d;

    // ---------------- outputs for the state being entered ----------------
    // Outputs are decoded from the next state so they appear registered in
    // the bus state they belong to.
    ale_d    = 1'b0;
    rd_d     = 1'b1;
    wr_d     = 1'b1;
    den_d    = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = ad_out_q;
    iom_d    = iom_q;   // IOM/DTR only change in T1 while DEN is inactive
    dtr_d    = dtr_q;
    a_d      = a_q;
    busy_d   = 1'b1;

    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_T1: begin
        ale_d    = 1'b1;
        a_d      = bus_addr_d[AW-1:8];
        ad_out_d = bus_addr_d[7:0];
        ad_oe_d  = 1'b1;
        iom_d    = io_d;
        dtr_d    = we_d;
      end
      S_T2, S_T3, S_TW: begin
        den_d    = 1'b0;
        rd_d     = we_d;
        wr_d     = ~we_d;
        // AD is released on reads so the responder can drive it.
        ad_oe_d  = we_d;
        ad_out_d = wdata_d;
      end
      S_T4: begin
        // Strobes and transceiver off; IOM/DTR hold.
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      io_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      wait_cnt_q <= 8'd0;
      rdata_q    <= 8'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ale_q      <= 1'b0;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      iom_q      <= 1'b0;
      dtr_q      <= 1'b0;
      den_q      <= 1'b1;
      a_q        <= '0;
      ad_out_q   <= 8'd0;
      ad_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      io_q       <= io_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      ale_q      <= ale_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      iom_q      <= iom_d;
      dtr_q      <= dtr_d;
      den_q      <= den_d;
      a_q        <= a_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign ALE   = ale_q;
  assign RD    = rd_q;
  assign WR    = wr_q;
  assign IOM   = iom_q;
  assign DTR   = dtr_q;
  assign DEN   = den_q;
  assign A     = a_q;
  assign AD    = ad_oe_q ? ad_out_q : 8'bz;

endmodule
